detect2600_scan: RTL and testbench
==================================

# detect2600_scan

Sequencer that drives the 2600 bankswitch detector after a cartridge load. On `start` it reads the loaded ROM image byte-by-byte from cart memory through a request/acknowledge port, replays it into the detector's `addr/data/enable` inputs (including the address-0 clear and a trailing flush beat), waits for the detector outputs to settle, then latches a final bankswitch code and Superchip flag for the 2600 cart mapper. It sits between the ROM loader/SDRAM arbiter and `detect2600`.

## Interface
Parameters:
- `DRAIN`, default 4: idle cycles after the flush beat before sampling detector outputs (1..15).

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a scan. Ignored while `busy`.
- `scan_len` in 14: number of bytes to scan, 0..8192; values above 8192 are clamped to 8192.
- `ext_bs` in 4: bankswitch code forced by file extension; 0 means none.
- `mem_req` out 1: read request to cart memory.
- `mem_addr` out 13: read byte address, stable while `mem_req`=1.
- `mem_ack` in 1: read complete; `mem_data` is valid in the same cycle.
- `mem_data` in 8: read data.
- `det_addr` out 13: detector address.
- `det_data` out 8: detector data.
- `det_enable` out 1: detector byte strobe.
- `det_force_bs` in 4: detector bankswitch result.
- `det_sc` in 1: detector Superchip result.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse; results valid.
- `bs_out` out 4: latched bankswitch code.
- `sc_out` out 1: latched Superchip flag.

## Operation
- States: IDLE, FETCH, FEED, FLUSH, DRAIN, LATCH, DONE.
- IDLE:
  - `busy`=0.
  - `start`=1 with effective length N>0: clear the byte counter to 0 and go to FETCH.
  - `start`=1 with N=0: go to LATCH and skip the scan.
- FETCH:
  - `mem_req`=1, `mem_addr`=counter.
  - Hold both until `mem_ack`=1; on that cycle register `mem_data` and go to FEED.
- FEED:
  - `det_enable`=1 for exactly one cycle, with `det_addr`=counter and `det_data`=registered byte.
  - Counter=N−1: go to FLUSH. Otherwise increment the counter and go to FETCH.
  - The first beat always carries address 0, which clears the detector.
- FLUSH:
  - `det_enable`=1, `det_addr`=13'h1FFF, `det_data`=8'h00.
  - Purpose: the detector compares its history on the following strobe, so this beat evaluates the final N bytes.
  - Go to DRAIN.
- DRAIN: count DRAIN cycles with `det_enable`=0, then go to LATCH.
- LATCH:
  - `bs_out` = `ext_bs` if nonzero, else `det_force_bs`.
  - `sc_out` = `det_sc` if N>0, else 0.
  - Go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `mem_ack` is ignored outside FETCH.
- `det_addr` and `det_data` hold their last values when `det_enable`=0.
- `bs_out` and `sc_out` hold their values until the next LATCH or reset.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req`=0, `mem_addr`=0.
  - `det_enable`=0, `det_addr`=0, `det_data`=0.
  - `busy`=0, `done`=0.
  - `bs_out`=0, `sc_out`=0.
- Reset mid-scan:
  - `mem_req` and `det_enable` are low in the first cycle after the reset edge.
  - The aborted scan produces no `done`.
- `start` sampled at edge 0 → `busy`=1 from cycle 1.
- With `mem_ack` returned in the same cycle as the request:
  - 2 cycles per byte.
  - FLUSH in cycle 2N+1.
  - DRAIN in cycles 2N+2..2N+1+DRAIN.
  - LATCH in cycle 2N+DRAIN+2.
  - `done` and valid outputs in cycle 2N+DRAIN+3.
- Each extra wait cycle before `mem_ack` adds exactly one cycle.
- N=0: LATCH in cycle 1, `done` in cycle 2.
- `start` during `busy` (including DONE) has no effect.
- `start` in the cycle after DONE, with the state back in IDLE, is accepted.

## Test plan
- Zero-wait scan: N=4, `mem_ack` held 1, DRAIN=4, `det_force_bs`=5 → `det_enable` pulses at addresses 0,1,2,3 then 1FFF; `done` in cycle 15; `bs_out`=5.
- Wait states: N=3, `mem_ack` 2 cycles after each request → `mem_addr` stable through each wait; `done` in cycle 3·2+6+3+4=19.
- Extension override: `ext_bs`=9, `det_force_bs`=3 → `bs_out`=9; with `ext_bs`=0 → `bs_out`=3.
- Clamp and empty scan:
  - `scan_len`=9000 → last FEED `det_addr`=1FFF and 8192 strobes before flush.
  - `scan_len`=0 → no `mem_req`; `done` in cycle 2; `sc_out`=0.
- Reset mid-FETCH (N=100, reset at byte 40) → `mem_req`=0 next cycle, no `done`, outputs 0; a fresh `start` rescans from address 0.
- `start` pulsed while `busy` → ignored; exactly one `done` per accepted start.

Source files
------------

// File: rtl/detect2600_scan.sv
// Replays a freshly loaded 2600 ROM image into the bankswitch detector and latches
// its verdict (bankswitch code + Superchip flag) for the cart mapper.
module detect2600_scan #(
  parameter int unsigned DRAIN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] scan_len,
  input  logic [3:0]  ext_bs,
  output logic        mem_req,
  output logic [12:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [12:0] det_addr,
  output logic [7:0]  det_data,
  output logic        det_enable,
  input  logic [3:0]  det_force_bs,
  input  logic        det_sc,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bs_out,
  output logic        sc_out
);

  localparam logic [13:0] MaxLen    = 14'd8192;
  localparam logic [3:0]  DrainLast = 4'(DRAIN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StFeed,
    StFlush,
    StDrain,
    StLatch,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] len_q, len_d;
  logic [12:0] cnt_q, cnt_d;
  logic [3:0]  drain_q, drain_d;
  logic [12:0] det_addr_q, det_addr_d;
  logic [7:0]  det_data_q, det_data_d;
  logic [3:0]  bs_q, bs_d;
  logic        sc_q, sc_d;

  logic [13:0] eff_len;
  logic        last_byte;

  assign eff_len   = (scan_len > MaxLen) ? MaxLen : scan_len;
  assign last_byte = ({1'b0, cnt_q} == (len_q - 14'd1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (eff_len == 14'd0) ? StLatch : StFetch;
        end
      end
      StFetch: begin
        if (mem_ack) begin
          state_d = StFeed;
        end
      end
      StFeed:  state_d = last_byte ? StFlush : StFetch;
      StFlush: state_d = StDrain;
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StLatch;
        end
      end
      StLatch: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_req    = (state_q == StFetch);
    det_enable = (state_q == StFeed) || (state_q == StFlush);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

  // Datapath next-state; detector address/data only move on the edge entering a strobe
  always_comb begin
    len_d      = len_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    det_addr_d = det_addr_q;
    det_data_d = det_data_q;
    bs_d       = bs_q;
    sc_d       = sc_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          len_d = eff_len;
          cnt_d = 13'd0;
        end
      end
      StFetch: begin
        if (mem_ack) begin
          det_addr_d = cnt_q;
          det_data_d = mem_data;
        end
      end
      StFeed: begin
        if (last_byte) begin
          // Trailing beat makes the detector evaluate the final bytes it saw
          det_addr_d = 13'h1FFF;
          det_data_d = 8'h00;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      StFlush: drain_d = 4'd0;
      StDrain: drain_d = drain_q + 4'd1;
      StLatch: begin
        bs_d = (ext_bs != 4'd0) ? ext_bs : det_force_bs;
        sc_d = (len_q != 14'd0) && det_sc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= 14'd0;
      cnt_q      <= 13'd0;
      drain_q    <= 4'd0;
      det_addr_q <= 13'd0;
      det_data_q <= 8'd0;
      bs_q       <= 4'd0;
      sc_q       <= 1'b0;
    end else begin
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      det_addr_q <= det_addr_d;
      det_data_q <= det_data_d;
      bs_q       <= bs_d;
      sc_q       <= sc_d;
    end
  end

  assign mem_addr = cnt_q;
  assign det_addr = det_addr_q;
  assign det_data = det_data_q;
  assign bs_out   = bs_q;
  assign sc_out   = sc_q;

endmodule

// File: tb/tb_detect2600_scan.sv
// Directed bench for detect2600_scan: vector table of whole scans plus reset-abort
// and start-while-busy sequences.
module tb_detect2600_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] scan_len = 14'd0;
  logic [3:0]  ext_bs = 4'd0;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'd0;
  logic [12:0] det_addr;
  logic [7:0]  det_data;
  logic        det_enable;
  logic [3:0]  det_force_bs = 4'd0;
  logic        det_sc = 1'b0;
  logic        busy;
  logic        done;
  logic [3:0]  bs_out;
  logic        sc_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  detect2600_scan #(.DRAIN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .scan_len     (scan_len),
    .ext_bs       (ext_bs),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .det_addr     (det_addr),
    .det_data     (det_data),
    .det_enable   (det_enable),
    .det_force_bs (det_force_bs),
    .det_sc       (det_sc),
    .busy         (busy),
    .done         (done),
    .bs_out       (bs_out),
    .sc_out       (sc_out)
  );

  typedef struct {
    logic [13:0] len;
    logic [3:0]  ext;
    logic [3:0]  dbs;
    logic        dsc;
    int          wt;       // wait cycles before ack
    logic        hold;     // ack held high throughout
    int          exp_done;
    logic [3:0]  exp_bs;
    logic        exp_sc;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [7:0] rom(input logic [12:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_scan(input vec_t v, input string nm);
    int n, strobes, reqs, req_cnt, done_cyc, dones, seq_errs, addr_errs;
    logic busy1, busy_after;
    logic [3:0] bs_seen;
    logic sc_seen;
    logic [12:0] exp_a, last_feed;
    logic [7:0] exp_d;
    n = (v.len > 14'd8192) ? 8192 : int'(v.len);
    strobes = 0; reqs = 0; req_cnt = 0; done_cyc = -1; dones = 0;
    seq_errs = 0; addr_errs = 0; busy1 = 1'b0; busy_after = 1'b1;
    bs_seen = 4'd0; sc_seen = 1'b0; last_feed = 13'd0;
    @(negedge clk);
    scan_len = v.len; ext_bs = v.ext; det_force_bs = v.dbs; det_sc = v.dsc;
    mem_ack = v.hold; start = 1'b1;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) busy1 = busy;
      mem_data = rom(mem_addr);
      if (mem_req) begin
        reqs++;
        if (mem_addr != 13'(strobes)) addr_errs++;
        mem_ack = v.hold || (req_cnt == v.wt);
        req_cnt++;
      end else begin
        req_cnt = 0;
        mem_ack = v.hold;
      end
      if (det_enable) begin
        exp_a = (strobes < n) ? 13'(strobes) : 13'h1FFF;
        exp_d = (strobes < n) ? rom(exp_a) : 8'h00;
        if (det_addr != exp_a || det_data != exp_d) seq_errs++;
        if (strobes == n - 1) last_feed = det_addr;
        strobes++;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc; bs_seen = bs_out; sc_seen = sc_out;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    mem_ack = 1'b0;
    check({nm, ".busy_cycle1"}, busy1, 1);
    check({nm, ".done_cycle"}, done_cyc, v.exp_done);
    check({nm, ".done_count"}, dones, 1);
    check({nm, ".bs_out"}, bs_seen, v.exp_bs);
    check({nm, ".sc_out"}, sc_seen, v.exp_sc);
    check({nm, ".strobes"}, strobes, (n == 0) ? 0 : n + 1);
    check({nm, ".strobe_seq_errs"}, seq_errs, 0);
    check({nm, ".mem_addr_errs"}, addr_errs, 0);
    check({nm, ".busy_after_done"}, busy_after, 0);
    if (n == 0) check({nm, ".mem_reqs"}, reqs, 0);
    else check({nm, ".last_feed_addr"}, last_feed, n - 1);
  endtask

  initial begin
    int req_cnt, dones, first_done, second_done;
    logic found, busy14;

    //            len       ext   dbs    sc    wt hold done   bs     sc
    vecs[0] = '{14'd4,    4'd0, 4'd5,  1'b0, 0, 1'b1, 15,    4'd5,  1'b0};
    vecs[1] = '{14'd3,    4'd0, 4'd7,  1'b1, 2, 1'b0, 19,    4'd7,  1'b1};
    vecs[2] = '{14'd2,    4'd9, 4'd3,  1'b0, 0, 1'b0, 11,    4'd9,  1'b0};
    vecs[3] = '{14'd2,    4'd0, 4'd3,  1'b1, 1, 1'b0, 13,    4'd3,  1'b1};
    vecs[4] = '{14'd0,    4'd0, 4'd3,  1'b1, 0, 1'b0, 2,     4'd3,  1'b0};
    vecs[5] = '{14'd9000, 4'd0, 4'd12, 1'b1, 0, 1'b0, 16391, 4'd12, 1'b1};
    vecs[6] = '{14'd1,    4'd0, 4'd6,  1'b1, 3, 1'b0, 12,    4'd6,  1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.mem_req", mem_req, 0);
    check("reset.mem_addr", mem_addr, 0);
    check("reset.det_enable", det_enable, 0);
    check("reset.det_addr", det_addr, 0);
    check("reset.det_data", det_data, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.bs_out", bs_out, 0);
    check("reset.sc_out", sc_out, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

    // Reset while fetching byte 40 of a 100-byte scan
    @(negedge clk);
    scan_len = 14'd100; ext_bs = 4'd0; det_force_bs = 4'd2; det_sc = 1'b1;
    start = 1'b1; req_cnt = 0; found = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      mem_data = rom(mem_addr);
      if (mem_req) begin
        if (mem_addr == 13'd40) begin
          found = 1'b1;
          break;
        end
        mem_ack = (req_cnt == 1);
        req_cnt++;
      end else begin
        req_cnt = 0;
        mem_ack = 1'b0;
      end
    end
    check("abort.reached_byte40", found, 1);
    reset = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    check("abort.mem_req", mem_req, 0);
    check("abort.det_enable", det_enable, 0);
    check("abort.busy", busy, 0);
    check("abort.bs_out", bs_out, 0);
    check("abort.sc_out", sc_out, 0);
    check("abort.mem_addr", mem_addr, 0);
    reset = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort.no_done", dones, 0);
    run_scan(vecs[2], "rescan");

    // start pulses while busy (incl. DONE) are ignored; start right after DONE is taken
    @(negedge clk);
    scan_len = 14'd3; ext_bs = 4'd0; det_force_bs = 4'd4; det_sc = 1'b0;
    mem_ack = 1'b1; start = 1'b1;
    dones = 0; first_done = -1; second_done = -1; busy14 = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      mem_data = rom(mem_addr);
      start = (cyc == 3) || (cyc == 8) || (cyc == 13) || (cyc == 14);
      if (cyc == 14) busy14 = busy;
      if (done) begin
        dones++;
        if (first_done < 0) first_done = cyc;
        else if (second_done < 0) second_done = cyc;
      end
    end
    start = 1'b0; mem_ack = 1'b0;
    check("busy_start.done_count", dones, 2);
    check("busy_start.first_done", first_done, 13);
    check("busy_start.idle_after_done", busy14, 0);
    check("busy_start.second_done", second_done, 27);
    check("busy_start.bs_out", bs_out, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
